pipe_share_arbiter: RTL



---
 rtl/svm_arb_pkg.sv | 22 ++
 rtl/outstanding_counter.sv | 37 +++
 rtl/pipe_share_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/svm_arb_pkg.sv
// Shared types, defaults and helpers for the SVM pipeline-sharing arbiter.
package svm_arb_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_LAT     = 6;
  localparam int unsigned DEF_MAX_OUT = 3;

  // Widest requester vector onehot_to_idx can decode.
  localparam int unsigned MAX_REQ = 32;

  typedef logic [7:0] cnt_t;

  function automatic logic [4:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/outstanding_counter.sv
// Per-requester in-flight operation counter with limit and nonzero flags.
module outstanding_counter
  import svm_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  cnt_t limit,
  output logic at_limit,
  output logic nonzero
);

  cnt_t cnt_q, cnt_d;

  // A return with nothing outstanding is illegal; hold at zero rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == limit);
  assign nonzero  = (cnt_q != '0);

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin issue arbiter for a shared fixed-latency pipeline, with a tag line
// that routes each result back to its requester and per-requester flow control.
module pipe_share_arbiter
  import svm_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned LAT     = DEF_LAT,
  parameter int unsigned MAX_OUT = DEF_MAX_OUT,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            stall,
  output logic [NREQ-1:0] grant,
  output logic            issue_valid,
  output logic [IDW-1:0]  issue_id,
  output logic [NREQ-1:0] ret_valid,
  output logic            busy
);

  logic [NREQ-1:0] at_limit;
  logic [NREQ-1:0] nonzero;
  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  pos;
  logic            found;

  logic            tag_valid_q [LAT];
  logic [IDW-1:0]  tag_id_q    [LAT];

  assign eligible = req & ~at_limit;

  // First eligible index at or after rr_q, wrapping at NREQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    if (!rst && !stall) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        pos = IDW'((32'(rr_q) + k) % NREQ);
        if (!found && eligible[pos]) begin
          grant[pos] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign issue_valid = |grant;
  assign issue_id    = IDW'(onehot_to_idx(MAX_REQ'(grant)));

  always_comb begin
    rr_d = rr_q;
    if (issue_valid) begin
      rr_d = (issue_id == IDW'(NREQ - 1)) ? '0 : issue_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Tag line always shifts; a stall just leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) tag_valid_q[i] <= 1'b0;
    end else begin
      tag_valid_q[0] <= issue_valid;
      for (int unsigned i = 1; i < LAT; i++) tag_valid_q[i] <= tag_valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q[0] <= issue_id;
    for (int unsigned i = 1; i < LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  // Outputs read zero while reset is held, before the registers have cleared.
  always_comb begin
    ret_valid = '0;
    if (!rst && tag_valid_q[LAT-1]) ret_valid[tag_id_q[LAT-1]] = 1'b1;
  end

  assign busy = !rst && (|nonzero);

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    outstanding_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (grant[i]),
      .dec      (ret_valid[i]),
      .limit    (cnt_t'(MAX_OUT)),
      .at_limit (at_limit[i]),
      .nonzero  (nonzero[i])
    );
  end

endmodule
